// File: rtl/ap_handshake_tracker_if.sv
// Handshake/record bundle for ap_handshake_tracker.
//   mon_start/mon_ready/mon_done/mon_continue : ap_ctrl_hs signals of the observed block
//   rec_valid/rec_ready                       : record stream handshake (FWFT)
//   rec_start_ts/rec_latency/rec_interval     : record payload, TS_W bits each
// slave  : the tracker (observes mon_*, produces rec_*)
// master : the environment (drives mon_* and rec_ready, consumes rec_*)
interface ap_handshake_tracker_if #(
  parameter int TS_W = 32
);
  logic            mon_start;
  logic            mon_ready;
  logic            mon_done;
  logic            mon_continue;
  logic            rec_valid;
  logic            rec_ready;
  logic [TS_W-1:0] rec_start_ts;
  logic [TS_W-1:0] rec_latency;
  logic [TS_W-1:0] rec_interval;

  modport master (
    output mon_start, mon_ready, mon_done, mon_continue, rec_ready,
    input  rec_valid, rec_start_ts, rec_latency, rec_interval
  );

  modport slave (
    input  mon_start, mon_ready, mon_done, mon_continue, rec_ready,
    output rec_valid, rec_start_ts, rec_latency, rec_interval
  );
endinterface

// File: rtl/ap_handshake_tracker.sv
// ap_handshake_tracker: watches an ap_ctrl_hs block and produces one record per
// completed transaction {start stamp, start->done latency, start->start interval}.
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset (deassertion synchronized)
//   bus              : ap_handshake_tracker_if.slave (mon_* in, rec_* stream out)
//   finish           : level end-of-test request; stops tracking and drains records
//   drop_cnt         : saturating count of lost starts/records
//   orphan_cnt       : saturating count of done events with no matching start
//   infl_ovf         : sticky, a start was lost because in-flight storage was full
//   stat_done        : tracking ended and all records drained
module ap_handshake_tracker #(
  parameter int TS_W       = 32,
  parameter int INFL_DEPTH = 4,
  parameter int OUT_DEPTH  = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  ap_handshake_tracker_if.slave        bus,
  input  logic                         finish,
  output logic [15:0]                  drop_cnt,
  output logic [15:0]                  orphan_cnt,
  output logic                         infl_ovf,
  output logic                         stat_done
);

  localparam int IA  = $clog2(INFL_DEPTH);
  localparam int ICW = IA + 1;
  localparam int OA  = $clog2(OUT_DEPTH);
  localparam int OCW = OA + 1;
  localparam int RW  = 3 * TS_W;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  // Reset: assertion acts immediately, release is retimed through two flops so
  // the whole block leaves reset on a clean edge with the counter at 0.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] prev_ts;
  logic            have_prev;
  logic [TS_W-1:0] interval;

  logic [TS_W-1:0] infl_ts_mem [INFL_DEPTH];
  logic [TS_W-1:0] infl_iv_mem [INFL_DEPTH];
  logic [IA-1:0]   infl_wr, infl_rd;
  logic [ICW-1:0]  infl_count;

  logic [RW-1:0]   out_mem [OUT_DEPTH];
  logic [OA-1:0]   out_wr, out_rd;
  logic [OCW-1:0]  out_count;

  logic run;
  logic start_ev, done_ev;
  logic infl_empty, infl_full, infl_push, infl_pop;
  logic start_drop, orphan;
  logic rec_gen, rec_full, rec_push, rec_pop, rec_drop;
  logic [RW-1:0] rec_word;

  // Next-state and run enable
  always_comb begin
    state_next = state;
    run        = 1'b0;
    unique case (state)
      RUN: begin
        run = 1'b1;
        if (finish) state_next = DRAIN;
      end
      DRAIN: begin
        // No pushes happen in DRAIN, so the FIFO is empty next cycle when it
        // is empty now or its last entry is being popped.
        if (out_count == '0 || (out_count == OCW'(1) && rec_pop)) state_next = DONE;
      end
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  assign start_ev   = run & bus.mon_start & bus.mon_ready;
  assign done_ev    = run & bus.mon_done & bus.mon_continue;
  assign interval   = have_prev ? ts - prev_ts : '0;

  assign infl_empty = (infl_count == '0);
  assign infl_full  = (infl_count == ICW'(INFL_DEPTH));
  assign infl_pop   = done_ev & ~infl_empty;
  // With a simultaneous done the pop frees a slot (or the start bypasses when empty).
  assign infl_push  = start_ev & (done_ev ? ~infl_empty : ~infl_full);
  assign start_drop = start_ev & ~done_ev & infl_full;
  assign orphan     = done_ev & infl_empty & ~start_ev;

  assign rec_gen    = done_ev & (~infl_empty | start_ev);
  assign rec_word   = infl_empty ? {ts, {TS_W{1'b0}}, interval}
                                 : {infl_ts_mem[infl_rd], ts - infl_ts_mem[infl_rd],
                                    infl_iv_mem[infl_rd]};

  assign bus.rec_valid = (out_count != '0);
  assign rec_pop    = bus.rec_valid & bus.rec_ready;
  assign rec_full   = (out_count == OCW'(OUT_DEPTH));
  assign rec_push   = rec_gen & (~rec_full | rec_pop);
  assign rec_drop   = rec_gen & ~rec_push;

  assign {bus.rec_start_ts, bus.rec_latency, bus.rec_interval} =
    bus.rec_valid ? out_mem[out_rd] : '0;

  assign stat_done  = (state == DONE);

  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state      <= RUN;
      ts         <= '0;
      prev_ts    <= '0;
      have_prev  <= 1'b0;
      infl_wr    <= '0;
      infl_rd    <= '0;
      infl_count <= '0;
      out_wr     <= '0;
      out_rd     <= '0;
      out_count  <= '0;
      drop_cnt   <= '0;
      orphan_cnt <= '0;
      infl_ovf   <= 1'b0;
    end else begin
      state <= state_next;
      ts    <= ts + TS_W'(1);

      if (start_ev) begin
        prev_ts   <= ts;
        have_prev <= 1'b1;
      end

      if (state == DRAIN) begin
        infl_wr    <= '0;
        infl_rd    <= '0;
        infl_count <= '0;
      end else begin
        if (infl_push) infl_wr <= infl_wr + IA'(1);
        if (infl_pop)  infl_rd <= infl_rd + IA'(1);
        case ({infl_push, infl_pop})
          2'b10:   infl_count <= infl_count + ICW'(1);
          2'b01:   infl_count <= infl_count - ICW'(1);
          default: infl_count <= infl_count;
        endcase
      end

      if (rec_push) out_wr <= out_wr + OA'(1);
      if (rec_pop)  out_rd <= out_rd + OA'(1);
      case ({rec_push, rec_pop})
        2'b10:   out_count <= out_count + OCW'(1);
        2'b01:   out_count <= out_count - OCW'(1);
        default: out_count <= out_count;
      endcase

      // A start drop needs no done and a record drop needs a done: never both.
      if ((start_drop | rec_drop) && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
      if (orphan && orphan_cnt != '1) orphan_cnt <= orphan_cnt + 16'd1;
      if (start_drop) infl_ovf <= 1'b1;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers/counts.
  always_ff @(posedge ap_clk) begin
    if (infl_push) begin
      infl_ts_mem[infl_wr] <= ts;
      infl_iv_mem[infl_wr] <= interval;
    end
    if (rec_push) out_mem[out_wr] <= rec_word;
  end

endmodule
